exconv_fp32_pck16_pipe: RTL
===========================

// Module: exconv_fp32_pck16_pipe
// PURPOSE
//  Multi-lane FP32->FP16 pack converter with a valid/ready pipeline. LANES
//  floats are packed into LANES halves per transaction.
//  - Full IEEE range handling; round-to-nearest-even or truncate.
//  - Overflow can be set to saturate to the largest finite value.
//  - Per-transaction exception flags plus sticky status flags.
//  - Sits in the EX-stage SIMD convert path (PCK-F32-to-F16 ops), between
//    operand fetch and writeback.
// PARAMETERS
//  LANES  4  number of FP32->FP16 lanes per transaction (1..8)
// PORTS
//  clock      in   1         core clock, all state on rising edge
//  reset_n    in   1         reset, asynchronous, active-low
//  in_valid   in   1         input transaction valid
//  in_ready   out  1         converter accepts input this cycle
//  in_data    in   32*LANES  lane i = in_data[32*i+31:32*i], FP32
//  in_mode    in   2         [0]=truncate (else RNE), [1]=saturate on overflow
//  out_valid  out  1         output transaction valid
//  out_ready  in   1         downstream accepts output
//  out_data   out  16*LANES  lane i = out_data[16*i+15:16*i], FP16
//  out_exc    out  4         OR over lanes of {NV,OF,UF,NX} for this output
//  sts_flags  out  4         sticky {NV,OF,UF,NX}
//  clr_flags  in   1         clears sts_flags
// BEHAVIOUR
//  - Reset: the following are all 0: s1/s2 valid, out_valid, out_data,
//    out_exc and sts_flags. in_ready is 1.
//  - Pipeline: S1 (classify+round) -> S2 (pack, output register).
//    - adv = !out_valid | out_ready. in_ready = adv.
//    - Both stages load only when adv; global stall, bubbles are not collapsed.
//    - Latency is 2 cycles from accept to out_valid; throughput is 1 per cycle.
//    - in_mode is captured with in_data; it is per-transaction.
//  - Per lane: s=bit31, e=bits30:23, m=bits22:0.
//    - e==255, m==0: out {s,1F,000}.
//    - e==255, m!=0: out {s,1F,1,m[21:13]}. NV is set if m[22]==0 (sNaN).
//    - e>=143: overflow. OF+NX; out {s,1F,000}, or {s,1E,3FF} if sat.
//    - 113<=e<=142: out {s, e-112, m[22:13]}, rounded.
//      - g=m[12], st=|m[11:0].
//      - RNE: increment when g&(st|m[13]). Truncate: never increment.
//      - Mantissa carry increments the exponent. Exponent reaching 31 is
//        handled as overflow.
//      - NX when g|st.
//    - e<113, input nonzero (m!=0 or e!=0): underflow path (see
//      CONFIGURATION). Zero inputs give {s,00,000} with no flags.
//  - out_exc accompanies out_data and holds while stalled.
//  - sts_flags <= (clr_flags ? 0 : sts_flags) | (new S2 load ? exc : 0).
//    Clear and a same-cycle event: the event survives.
//  - Reset mid-transaction: in-flight data is discarded and out_valid drops
//    immediately (async).
// CONFIGURATION
//  FP16_DENORM_EN defined:
//   - 103<=e<=112 produces an FP16 subnormal:
//     - sig=(1<<23)|m, shifted right by 126-e.
//     - Rounded RNE or truncate using the shifted-out g/st bits.
//     - A round-up into 0x400 yields the smallest normal, {s,01,000}.
//   - e<103 rounds to zero (RNE may round to {s,00,001} at e==102).
//   - UF is set if the result is inexact. NX is set if inexact.
//  FP16_DENORM_EN undefined:
//   - All e<113 nonzero inputs flush to {s,00,000}.
//   - UF and NX are set.
// TESTING
//  - 0x3F800000 mode 0 -> 0x3C00, exc 0, out_valid 2 cycles after accept.
//  - 0x3F803000 RNE -> 0x3C02 NX; 0x3F801000 RNE -> 0x3C00 NX;
//    0x3F803000 trunc -> 0x3C01 NX.
//  - 0x477FF000: mode 0 -> 0x7C00 OF|NX; mode 2 -> 0x7BFF OF|NX.
//    0xFF800000 -> 0xFC00, no flags.
//  - 0x7F800001 -> 0x7E00 NV; 0x7FC00000 -> 0x7E00, no NV.
//  - 0x33800000 -> 0x0001 (DENORM_EN, exact) or 0x0000 UF|NX (without).
//  - Hold out_ready=0 for 5 cycles with 3 txns offered:
//    - in_ready=0 while out_valid is held.
//    - out_data is stable and no txn is lost or duplicated.
//    - clr_flags with a concurrent NV event -> sts_flags=NV.

Source files
------------

// File: rtl/exconv_fp32_pck16_pipe.sv
// ============================================================================
// exconv_fp32_pck16_pipe : LANES x FP32->FP16 pack converter, 2-stage valid/ready
// Optional FP16 subnormal outputs: define FP16_DENORM_EN.      Revision: 1.0
// ============================================================================
`default_nettype none

module exconv_fp32_pck16_pipe #(
    parameter int LANES = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*LANES-1:0]  in_data,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*LANES-1:0]  out_data,
    output logic [3:0]           out_exc,
    output logic [3:0]           sts_flags,
    input  logic                 clr_flags
);

    localparam logic [14:0] C_INF_MAG = 15'h7C00;
    localparam logic [14:0] C_MAX_MAG = 15'h7BFF;
    localparam logic [14:0] C_QNAN_HI = 15'h7E00;

    // Returns {exc[3:0] = {NV,OF,UF,NX}, half[15:0]} for one lane.
    function automatic logic [19:0] cvt_lane(input logic [31:0] f, input logic [1:0] mode);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [14:0] mag;
        logic [14:0] sum;
        logic [14:0] ovf_mag;
        logic [3:0]  exc;
        logic        g;
        logic        st;
        logic        inc;
`ifdef FP16_DENORM_EN
        logic [7:0]  shift;
        logic [47:0] ext;
        logic        dg;
        logic        dst;
        logic        dinc;
`endif
        s       = f[31];
        e       = f[30:23];
        m       = f[22:0];
        g       = m[12];
        st      = |m[11:0];
        inc     = ~mode[0] & g & (st | m[13]);
        // A mantissa carry ripples into the exponent field through the add.
        sum     = {5'(e - 8'd112), m[22:13]} + 15'(inc);
        ovf_mag = mode[1] ? C_MAX_MAG : C_INF_MAG;
        mag     = '0;
        exc     = '0;

        if (e == 8'hFF) begin
            if (m == '0) begin
                mag = C_INF_MAG;
            end else begin
                mag    = C_QNAN_HI | {6'b0, m[21:13]};
                exc[3] = ~m[22];
            end
        end else if ((e >= 8'd143) || ((e >= 8'd113) && (sum[14:10] == 5'h1F))) begin
            mag = ovf_mag;
            exc = 4'b0101;
        end else if (e >= 8'd113) begin
            mag    = sum;
            exc[0] = g | st;
        end else if ((e != 8'd0) || (m != '0)) begin
`ifdef FP16_DENORM_EN
            shift = 8'd126 - e;
            // Beyond 24 bits of shift only a sticky remainder survives.
            if (shift > 8'd24) begin
                ext = 48'd1;
            end else begin
                ext = {1'b1, m, 24'b0} >> shift;
            end
            dg   = ext[23];
            dst  = |ext[22:0];
            dinc = ~mode[0] & dg & (dst | ext[24]);
            mag  = 15'(ext[47:24] + 24'(dinc));
            exc  = {2'b00, dg | dst, dg | dst};
`else
            exc = 4'b0011;
`endif
        end
        return {exc, s, mag};
    endfunction

    logic                  adv;
    logic [16*LANES-1:0]   cvt_data;
    logic [3:0]            cvt_exc;
    logic [19:0]           lane_res;

    logic                  s1_valid_q, s1_valid_d;
    logic [16*LANES-1:0]   s1_data_q,  s1_data_d;
    logic [3:0]            s1_exc_q,   s1_exc_d;
    logic                  out_valid_q, out_valid_d;
    logic [16*LANES-1:0]   out_data_q,  out_data_d;
    logic [3:0]            out_exc_q,   out_exc_d;
    logic [3:0]            sts_q,       sts_d;

    assign adv = ~out_valid_q | out_ready;

    always_comb begin
        cvt_data = '0;
        cvt_exc  = '0;
        lane_res = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_res              = cvt_lane(in_data[32*i +: 32], in_mode);
            cvt_data[16*i +: 16]  = lane_res[15:0];
            cvt_exc               = cvt_exc | lane_res[19:16];
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_exc_d    = s1_exc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_exc_d   = out_exc_q;
        sts_d       = clr_flags ? 4'b0000 : sts_q;
        if (adv) begin
            s1_valid_d  = in_valid;
            s1_data_d   = cvt_data;
            s1_exc_d    = cvt_exc;
            out_valid_d = s1_valid_q;
            out_data_d  = s1_data_q;
            // Bubbles carry no flags into the output or the sticky status.
            out_exc_d   = s1_valid_q ? s1_exc_q : 4'b0000;
            if (s1_valid_q) begin
                sts_d = sts_d | s1_exc_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_exc_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_exc_q   <= '0;
            sts_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_exc_q    <= s1_exc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_exc_q   <= out_exc_d;
            sts_q       <= sts_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_exc   = out_exc_q;
    assign sts_flags = sts_q;

endmodule

`default_nettype wire
